pkt_tx_source: RTL
==================

PKT_TX_SOURCE -- requirements
Module: pkt_tx_source

Interface
REQ-001 SHALL have parameter BUF_WORDS, default 512, frame-buffer depth in 32-bit words (max frame = 4*BUF_WORDS bytes).
REQ-002 SHALL have port clk  in  1  single clock for all logic.
REQ-003 SHALL have port reset  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have Avalon-MM slave ports: address in 2, write in 1, writedata in 32, read in 1, readdata out 32, chipselect in 1.
REQ-005 SHALL have Avalon-ST source ports: tx_data out 8, tx_valid out 1, tx_ready in 1, tx_sop out 1, tx_eop out 1.

Function
REQ-006 SHALL decode registers: 0 DATA (write-only), 1 LEN (R/W, bits 11:0, byte count), 2 CTRL (write: bit0 START, bit1 CLR), 3 STATUS (read-only).
REQ-007 SHALL define STATUS bits: 0 busy, 1 error (sticky), 25:16 wr_ptr, 31:26 frames_sent mod 64.
REQ-008 SHALL store each DATA write at wr_ptr, then increment wr_ptr; a write at wr_ptr==BUF_WORDS SHALL be dropped and set error.
REQ-009 SHALL ignore DATA and LEN writes while busy and set error.
REQ-010 SHALL accept START only in IDLE with 1<=LEN<=4*BUF_WORDS; otherwise it SHALL ignore START and set error.
REQ-011 SHALL implement FSM IDLE -> FETCH -> SEND -> IDLE; busy=1 outside IDLE.
REQ-012 SHALL, in FETCH, issue buffer read of word 0 and enter SEND one cycle later with tx_valid=1, so first byte is valid 2 cycles after START write.
REQ-013 SHALL emit bytes little-endian per word (writedata[7:0] first), tx_sop=1 on byte 0 only, tx_eop=1 on byte LEN-1 only.
REQ-014 SHALL advance a byte only on a cycle with tx_valid&&tx_ready; tx_data/sop/eop SHALL hold stable while tx_valid&&!tx_ready.
REQ-015 SHALL prefetch the next word so that with tx_ready held high one byte transfers every cycle, no bubbles at word boundaries.
REQ-016 SHALL, on EOP transfer, drop tx_valid next cycle, increment frames_sent (wraps 63->0), return to IDLE, and keep buffer and wr_ptr (START resends same frame).
REQ-017 SHALL, on CTRL CLR, reset wr_ptr to 0 and clear error; CLR while busy SHALL be ignored except error clear.
REQ-018 SHALL, when START and CLR written together in IDLE, perform START and ignore CLR.
REQ-019 SHALL have readdata valid the cycle after read (1-cycle read latency); reads of 0/2 return 0.

Reset
REQ-020 SHALL on reset asynchronously force IDLE, tx_valid=0, tx_sop=0, tx_eop=0, tx_data=0, readdata=0, wr_ptr=0, LEN=0, error=0, frames_sent=0; buffer contents undefined.
REQ-021 SHALL abort a frame in progress on reset with tx_valid low immediately; no EOP issued.

Structure
REQ-022 SHALL place register address constants, STATUS bit positions and FSM state enum in shared package pkt_filter_pkg.
REQ-023 SHALL instantiate one sub-module tx_buf: simple dual-port RAM, BUF_WORDS x 32, registered read, inferable as M10K.

Verification
REQ-024 Write 2 DATA words 0x44332211, 0x88776655, LEN=6, START, tx_ready=1 -> bytes 11,22,33,44,55,66 consecutive, sop on 11, eop on 66, first valid 2 cycles after START, STATUS frames_sent=1.
REQ-025 Same frame, tx_ready toggled 1,0,0,1 repeating -> identical byte sequence, data stable during stalls, no duplicates or drops.
REQ-026 LEN=0 then START -> no tx_valid, STATUS error=1, busy=0; CLR -> error=0, wr_ptr=0.
REQ-027 BUF_WORDS=4: write 5 DATA words -> wr_ptr=4, error=1; LEN=16 START -> 16 bytes, eop on byte 15.
REQ-028 DATA write and second START mid-frame -> frame unaffected, error=1; assert reset mid-frame -> tx_valid=0 same cycle, STATUS reads 0 after release.
REQ-029 LEN=1, START -> single transfer with sop=eop=1; 64 consecutive frames -> frames_sent wraps to 0.

Source files
------------

// File: rtl/pkt_filter_pkg.sv
// Shared register map, STATUS layout and FSM encoding for the packet TX source.
package pkt_filter_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_LEN    = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_CLR   = 1;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_ERROR   = 1;
    localparam int unsigned STAT_PTR_LSB = 16;
    localparam int unsigned STAT_FS_LSB  = 26;

    localparam int unsigned LEN_W = 12;
    localparam int unsigned PTR_W = 10;
    localparam int unsigned FS_W  = 6;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StSend
    } state_t;

    function automatic logic [31:0] pack_status(input logic busy, input logic err,
                                                input logic [PTR_W-1:0] ptr,
                                                input logic [FS_W-1:0] fs);
        logic [31:0] s;
        s                          = '0;
        s[STAT_BUSY]               = busy;
        s[STAT_ERROR]              = err;
        s[STAT_PTR_LSB +: PTR_W]   = ptr;
        s[STAT_FS_LSB +: FS_W]     = fs;
        return s;
    endfunction

endpackage

// File: rtl/tx_buf.sv
// Simple dual-port frame buffer: one write port, one registered read port.
module tx_buf #(
    parameter int unsigned WORDS = 512,
    parameter int unsigned AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/pkt_tx_source.sv
// Avalon-MM programmed frame buffer that streams its contents out as an Avalon-ST byte frame.
module pkt_tx_source
    import pkt_filter_pkg::*;
#(
    parameter int unsigned BUF_WORDS = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    input  logic        chipselect,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_sop,
    output logic        tx_eop
);

    localparam int unsigned AW        = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;
    localparam int unsigned LEN_CMP_W = LEN_W + 1;
    localparam logic [PTR_W-1:0]     PTR_END = PTR_W'(BUF_WORDS);
    localparam logic [LEN_CMP_W-1:0] MAX_LEN = LEN_CMP_W'(4 * BUF_WORDS);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  byte_cnt_q;
    logic [LEN_W-1:0]  byte_nxt;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic              error_q;
    logic [FS_W-1:0]   frames_q;
    logic [31:0]       readdata_q;
    logic [31:0]       rd_mux;
    logic [31:0]       rd_word;
    logic [7:0]        byte_sel;

    logic wr_en, rd_en, busy, len_ok, fire, last;
    logic start_req, start_ok, clr_req, data_req, buf_we, len_req, len_we, err_set;
    logic unused_nxt;

    assign wr_en     = chipselect && write;
    assign rd_en     = chipselect && read;
    assign busy      = (state_q != StIdle);
    assign len_ok    = (len_q != '0) && ({1'b0, len_q} <= MAX_LEN);

    assign start_req = wr_en && (address == ADDR_CTRL) && writedata[CTRL_START];
    assign clr_req   = wr_en && (address == ADDR_CTRL) && writedata[CTRL_CLR];
    assign start_ok  = start_req && !busy && len_ok;
    assign data_req  = wr_en && (address == ADDR_DATA);
    assign buf_we    = data_req && !busy && (wr_ptr_q != PTR_END);
    assign len_req   = wr_en && (address == ADDR_LEN);
    assign len_we    = len_req && !busy;
    assign err_set   = (data_req && !buf_we) || (len_req && busy) || (start_req && !start_ok);

    assign tx_valid  = (state_q == StSend);
    assign fire      = tx_valid && tx_ready;
    assign last      = (byte_cnt_q == len_q - 1'b1);

    // Read address tracks the byte that will be current next cycle, so a word boundary
    // crossing fetches the following word one cycle ahead and stalls keep the RAM output stable.
    assign byte_nxt  = fire ? byte_cnt_q + 1'b1 : byte_cnt_q;
    assign unused_nxt = ^byte_nxt;

    tx_buf #(
        .WORDS (BUF_WORDS),
        .AW    (AW)
    ) u_tx_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (writedata),
        .raddr (byte_nxt[AW+1:2]),
        .rdata (rd_word)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_ok) state_d = StFetch;
            StFetch: state_d = StSend;
            StSend:  if (fire && last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q      <= '0;
            byte_cnt_q <= '0;
            wr_ptr_q   <= '0;
            error_q    <= 1'b0;
            frames_q   <= '0;
            readdata_q <= '0;
        end else begin
            if (buf_we) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end else if (clr_req && !busy && !start_ok) begin
                wr_ptr_q <= '0;
            end
            if (len_we) begin
                len_q <= writedata[LEN_W-1:0];
            end
            if (err_set) begin
                error_q <= 1'b1;
            end else if (clr_req && !start_ok) begin
                error_q <= 1'b0;
            end
            if (fire) begin
                byte_cnt_q <= last ? '0 : byte_cnt_q + 1'b1;
            end
            if (fire && last) begin
                frames_q <= frames_q + 1'b1;
            end
            if (rd_en) begin
                readdata_q <= rd_mux;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (address)
            ADDR_LEN:    rd_mux = {{(32 - LEN_W){1'b0}}, len_q};
            ADDR_STATUS: rd_mux = pack_status(busy, error_q, wr_ptr_q, frames_q);
            default:     rd_mux = '0;
        endcase
    end

    always_comb begin
        byte_sel = 8'h00;
        unique case (byte_cnt_q[1:0])
            2'd0: byte_sel = rd_word[7:0];
            2'd1: byte_sel = rd_word[15:8];
            2'd2: byte_sel = rd_word[23:16];
            2'd3: byte_sel = rd_word[31:24];
            default: byte_sel = 8'h00;
        endcase
    end

    assign tx_data  = tx_valid ? byte_sel : 8'h00;
    assign tx_sop   = tx_valid && (byte_cnt_q == '0);
    assign tx_eop   = tx_valid && last;
    assign readdata = readdata_q;

endmodule
